// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } cache_state_t;

    function automatic int unsigned index_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned width, input int unsigned sets);
        return width - 2 - $clog2(sets);
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and backing-memory-side signals of the data cache in one bundle.
interface data_cache_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             cpu_req;
    logic             cpu_we;
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic [WIDTH-1:0] cpu_rdata;
    logic             stall;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty/tag/data per set, combinational read, synchronous write.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SETS  = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [index_bits(SETS)-1:0]          idx_i,
    input  logic                                 wr_en_i,
    input  logic                                 wr_dirty_i,
    input  logic [tag_bits(WIDTH, SETS)-1:0]     wr_tag_i,
    input  logic [WIDTH-1:0]                     wr_data_i,
    output logic                                 valid_o,
    output logic                                 dirty_o,
    output logic [tag_bits(WIDTH, SETS)-1:0]     tag_o,
    output logic [WIDTH-1:0]                     data_o
);
    localparam int unsigned TAG_W = tag_bits(WIDTH, SETS);

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [WIDTH-1:0] data_q [SETS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= wr_dirty_i;
        end
    end

    // Tag and data are deliberately left uncleared; valid gates their use.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_i) begin
            tag_q[idx_i]  <= wr_tag_i;
            data_q[idx_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache with a stalling miss FSM
// (write back dirty victim, then refill) over a req/ready memory handshake.
module data_cache
    import cache_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SETS  = 64
) (
    input logic         clk,
    input logic         rst,
    data_cache_if.slave bus
);
    localparam int unsigned IDX_W = index_bits(SETS);
    localparam int unsigned TAG_W = tag_bits(WIDTH, SETS);

    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic             line_valid;
    logic             line_dirty;
    logic [TAG_W-1:0] line_tag;
    logic [WIDTH-1:0] line_data;
    logic             hit;
    logic             unused_addr_bits;

    logic             wr_en;
    logic             wr_dirty;
    logic [TAG_W-1:0] wr_tag;
    logic [WIDTH-1:0] wr_data;

    cache_state_t     state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    assign cpu_idx          = bus.cpu_addr[2 +: IDX_W];
    assign cpu_tag          = bus.cpu_addr[WIDTH-1 -: TAG_W];
    assign unused_addr_bits = ^bus.cpu_addr[1:0];
    assign hit              = line_valid && (line_tag == cpu_tag);

    cache_line_array #(
        .WIDTH (WIDTH),
        .SETS  (SETS)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .idx_i      (cpu_idx),
        .wr_en_i    (wr_en),
        .wr_dirty_i (wr_dirty),
        .wr_tag_i   (wr_tag),
        .wr_data_i  (wr_data),
        .valid_o    (line_valid),
        .dirty_o    (line_dirty),
        .tag_o      (line_tag),
        .data_o     (line_data)
    );

    always_comb begin
        state_d       = state_q;
        bus.stall     = 1'b0;
        bus.cpu_rdata = '0;
        wr_en         = 1'b0;
        wr_dirty      = 1'b0;
        wr_tag        = cpu_tag;
        wr_data       = bus.cpu_wdata;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (hit) begin
                        if (bus.cpu_we) begin
                            wr_en    = 1'b1;
                            wr_dirty = 1'b1;
                        end else begin
                            bus.cpu_rdata = line_data;
                        end
                    end else begin
                        bus.stall = 1'b1;
                        state_d   = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.stall = 1'b1;
                if (bus.mem_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                bus.stall = 1'b1;
                if (bus.mem_ready) begin
                    wr_en   = 1'b1;
                    wr_data = bus.mem_rdata;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory outputs are loaded from the next state so they are valid in the
    // first cycle of WRITEBACK/ALLOCATE and stay stable until mem_ready.
    always_comb begin
        mem_req_d   = (state_d != IDLE);
        mem_we_d    = (state_d == WRITEBACK);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == WRITEBACK) begin
            mem_addr_d  = {line_tag, cpu_idx, 2'b00};
            mem_wdata_d = line_data;
        end else if (state_d == ALLOCATE) begin
            mem_addr_d  = {cpu_tag, cpu_idx, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized
// accesses against a line-level cache model and a word-addressed memory model.
module tb_data_cache;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned SETS  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_cache_if #(.WIDTH(WIDTH)) bus ();

    data_cache #(.WIDTH(WIDTH), .SETS(SETS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each set remembers the word address it holds.
    bit          m_valid [SETS];
    bit          m_dirty [SETS];
    logic [31:0] m_laddr [SETS];
    logic [31:0] m_data  [SETS];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bmem    [logic [31:0]];

    bit          e_miss, e_wb;
    logic [31:0] e_wb_addr, e_wb_data, e_rd_addr, e_rdata;

    int unsigned o_stall;
    bit          o_timeout, o_req_after;
    logic [31:0] o_rdata;
    logic [31:0] tx_addr [$];
    bit          tx_we   [$];
    logic [31:0] tx_data [$];

    function automatic logic [31:0] fill(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC3C3_1F1F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : fill(a);
    endfunction

    task automatic ref_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] a;
        int unsigned s;
        a = addr & 32'hFFFF_FFFC;
        s = (a / 4) % SETS;
        e_miss    = !(m_valid[s] && m_laddr[s] == a);
        e_wb      = e_miss && m_valid[s] && m_dirty[s];
        e_rd_addr = a;
        if (e_wb) begin
            e_wb_addr = m_laddr[s];
            e_wb_data = m_data[s];
            ref_mem[e_wb_addr] = e_wb_data;
        end
        if (e_miss) begin
            m_valid[s] = 1'b1;
            m_dirty[s] = 1'b0;
            m_laddr[s] = a;
            m_data[s]  = ref_rd(a);
        end
        if (we) begin
            m_data[s]  = wdata;
            m_dirty[s] = 1'b1;
        end
        e_rdata = m_data[s];
    endtask

    function automatic int unsigned exp_stall(input int unsigned lw, input int unsigned la);
        if (!e_miss) return 0;
        return 1 + (la + 1) + (e_wb ? lw + 1 : 0);
    endfunction

    // Entered just after a rising edge; plays CPU and memory until the access completes.
    task automatic cpu_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int unsigned lat_wb, input int unsigned lat_al);
        int unsigned cnt;
        bit done;
        cnt = 0; done = 0; o_stall = 0; o_rdata = '0;
        tx_addr.delete(); tx_we.delete(); tx_data.delete();
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.mem_req) begin
                cnt++;
                if (cnt > (bus.mem_we ? lat_wb : lat_al)) begin
                    bus.mem_ready = 1'b1;
                    cnt = 0;
                    tx_addr.push_back(bus.mem_addr);
                    tx_we.push_back(bus.mem_we);
                    tx_data.push_back(bus.mem_wdata);
                    if (bus.mem_we) bmem[bus.mem_addr] = bus.mem_wdata;
                    else            bus.mem_rdata = bmem_rd(bus.mem_addr);
                end
            end
            @(negedge clk);
            if (bus.stall) o_stall++;
            else begin
                done    = 1;
                o_rdata = bus.cpu_rdata;
            end
            @(posedge clk); #1;
        end
        o_timeout     = !done;
        bus.cpu_req   = 1'b0;
        bus.mem_ready = 1'b0;
        o_req_after   = bus.mem_req;
    endtask

    task automatic test_reset;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.stall, bus.mem_req, bus.mem_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall/req/we=%b expected 000", {bus.stall, bus.mem_req, bus.mem_we});
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: addr=%h wdata=%h expected 0", bus.mem_addr, bus.mem_wdata);
        end
        n_checks++;
        if (bus.cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", bus.cpu_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clean_miss;
        bmem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        ref_access(0, 32'h100, '0);
        cpu_access(0, 32'h100, '0, 0, 3);
        n_checks++;
        if (o_timeout || o_stall != 5) begin
            n_fail++;
            $display("FAIL clean_miss_stall: got %0d cycles (timeout=%0d) expected 5", o_stall, o_timeout);
        end
        n_checks++;
        if (tx_addr.size() != 1 || tx_addr[0] !== 32'h100 || tx_we[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_miss_tx: %0d transactions, first addr=%h expected 1 read at 100",
                     tx_addr.size(), tx_addr.size() > 0 ? tx_addr[0] : 32'hX);
        end
        n_checks++;
        if (o_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL clean_miss_rdata: got %h expected deadbeef", o_rdata);
        end
    endtask

    task automatic test_hit;
        ref_access(0, 32'h100, '0);
        cpu_access(0, 32'h100, '0, 0, 0);
        n_checks++;
        if (o_stall != 0 || tx_addr.size() != 0 || o_req_after !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_nostall: stall=%0d tx=%0d expected 0/0", o_stall, tx_addr.size());
        end
        n_checks++;
        if (o_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL hit_rdata: got %h expected deadbeef", o_rdata);
        end
    endtask

    task automatic test_dirty_evict;
        ref_access(1, 32'h100, 32'h1234_5678);
        cpu_access(1, 32'h100, 32'h1234_5678, 0, 0);
        ref_access(0, 32'h100, '0);
        cpu_access(0, 32'h100, '0, 0, 0);
        n_checks++;
        if (o_stall != 0 || o_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL store_hit_readback: stall=%0d rdata=%h expected 0/12345678", o_stall, o_rdata);
        end
        ref_access(0, 32'h200, '0);
        cpu_access(0, 32'h200, '0, 2, 1);
        n_checks++;
        if (o_stall != exp_stall(2, 1) || o_stall != 6) begin
            n_fail++;
            $display("FAIL dirty_miss_stall: got %0d expected 6", o_stall);
        end
        n_checks++;
        if (tx_addr.size() != 2) begin
            n_fail++;
            $display("FAIL dirty_miss_count: got %0d transactions expected 2", tx_addr.size());
        end else if (tx_we[0] !== 1'b1 || tx_addr[0] !== 32'h100 || tx_data[0] !== 32'h1234_5678
                     || tx_we[1] !== 1'b0 || tx_addr[1] !== 32'h200) begin
            n_fail++;
            $display("FAIL dirty_miss_tx: wb we=%0d addr=%h data=%h rd we=%0d addr=%h expected 1/100/12345678 0/200",
                     tx_we[0], tx_addr[0], tx_data[0], tx_we[1], tx_addr[1]);
        end
        n_checks++;
        if (o_rdata !== e_rdata) begin
            n_fail++;
            $display("FAIL dirty_miss_rdata: got %h expected %h", o_rdata, e_rdata);
        end
    endtask

    task automatic test_store_miss;
        ref_access(1, 32'h40, 32'hA5A5_A5A5);
        cpu_access(1, 32'h40, 32'hA5A5_A5A5, 0, 2);
        n_checks++;
        if (o_stall != 4 || tx_addr.size() != 1 || tx_addr[0] !== 32'h40 || tx_we[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL store_miss_refill: stall=%0d tx=%0d expected 4 cycles, 1 read at 40",
                     o_stall, tx_addr.size());
        end
        ref_access(0, 32'h140, '0);
        cpu_access(0, 32'h140, '0, 1, 1);
        n_checks++;
        if (tx_addr.size() != 2 || tx_we[0] !== 1'b1 || tx_addr[0] !== 32'h40 || tx_data[0] !== 32'hA5A5_A5A5
            || tx_addr[1] !== 32'h140) begin
            n_fail++;
            $display("FAIL store_miss_writeback: tx=%0d first=%h/%h expected wb 40/a5a5a5a5 then 140",
                     tx_addr.size(), tx_addr.size() > 0 ? tx_addr[0] : 32'hX,
                     tx_data.size() > 0 ? tx_data[0] : 32'hX);
        end
    endtask

    task automatic test_zero_latency;
        ref_access(1, 32'h0C, 32'h0BAD_F00D);
        cpu_access(1, 32'h0C, 32'h0BAD_F00D, 0, 0);
        n_checks++;
        if (o_stall != 2 || tx_addr.size() != 1 || o_req_after !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_lat_clean: stall=%0d tx=%0d req_after=%0d expected 2/1/0",
                     o_stall, tx_addr.size(), o_req_after);
        end
        ref_access(0, 32'h10C, '0);
        cpu_access(0, 32'h10C, '0, 0, 0);
        n_checks++;
        if (o_stall != 3 || tx_addr.size() != 2 || o_req_after !== 1'b0 || o_rdata !== e_rdata) begin
            n_fail++;
            $display("FAIL zero_lat_dirty: stall=%0d tx=%0d rdata=%h expected 3/2/%h",
                     o_stall, tx_addr.size(), o_rdata, e_rdata);
        end
    endtask

    task automatic test_reset_mid_miss;
        ref_access(0, 32'h304, '0);
        cpu_access(0, 32'h304, '0, 0, 1);
        ref_access(0, 32'h304, '0);
        cpu_access(0, 32'h304, '0, 0, 0);
        n_checks++;
        if (o_stall != 0) begin
            n_fail++;
            $display("FAIL pre_reset_hit: stall=%0d expected 0", o_stall);
        end
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h8;
        for (int c = 0; c < 20 && !bus.mem_req; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL allocate_req: req=%0d we=%0d expected 1/0", bus.mem_req, bus.mem_we);
        end
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop_req: got %0d expected 0", bus.mem_req);
        end
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop_stall: got %0d expected 0", bus.stall);
        end
        @(posedge clk); #1;
        for (int s = 0; s < SETS; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        ref_access(0, 32'h304, '0);
        cpu_access(0, 32'h304, '0, 0, 2);
        n_checks++;
        if (o_stall != 4 || tx_addr.size() != 1 || tx_addr[0] !== 32'h304) begin
            n_fail++;
            $display("FAIL post_reset_miss: stall=%0d tx=%0d expected 4 cycles, 1 read at 304",
                     o_stall, tx_addr.size());
        end
    endtask

    task automatic test_random;
        bit          we;
        logic [31:0] addr, wd, tg;
        int unsigned lw, la, rd_i;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            tg = 32'($urandom_range(0, 3));
            if (tg == 3) tg = 32'h00FF_FFFF;
            addr = (tg << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            wd = $urandom;
            lw = $urandom_range(0, 3);
            la = $urandom_range(0, 3);
            ref_access(we, addr, wd);
            cpu_access(we, addr, wd, lw, la);
            n_checks++;
            if (o_timeout || o_stall != exp_stall(lw, la)) begin
                n_fail++;
                $display("FAIL rand_stall[%0d]: addr=%h got %0d expected %0d", i, addr, o_stall, exp_stall(lw, la));
            end
            n_checks++;
            if (tx_addr.size() != (e_miss ? (e_wb ? 2 : 1) : 0) || o_req_after !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_txcount[%0d]: addr=%h got %0d req_after=%0d expected %0d",
                         i, addr, tx_addr.size(), o_req_after, e_miss ? (e_wb ? 2 : 1) : 0);
            end else if (e_miss) begin
                rd_i = e_wb ? 1 : 0;
                n_checks++;
                if (e_wb && (tx_we[0] !== 1'b1 || tx_addr[0] !== e_wb_addr || tx_data[0] !== e_wb_data)) begin
                    n_fail++;
                    $display("FAIL rand_wb[%0d]: got %h/%h expected %h/%h",
                             i, tx_addr[0], tx_data[0], e_wb_addr, e_wb_data);
                end
                n_checks++;
                if (tx_we[rd_i] !== 1'b0 || tx_addr[rd_i] !== e_rd_addr) begin
                    n_fail++;
                    $display("FAIL rand_refill[%0d]: got %h expected %h", i, tx_addr[rd_i], e_rd_addr);
                end
            end
            if (!we) begin
                n_checks++;
                if (o_rdata !== e_rdata) begin
                    n_fail++;
                    $display("FAIL rand_rdata[%0d]: addr=%h got %h expected %h", i, addr, o_rdata, e_rdata);
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                n_checks++;
                if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle[%0d]: stall=%0d req=%0d expected 0/0", i, bus.stall, bus.mem_req);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_hit();
        test_dirty_evict();
        test_store_miss();
        test_zero_latency();
        test_reset_mid_miss();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
